bus_rr_arbiter: RTL
===================

Name: bus_rr_arbiter

Overview:
- Shares one device port between NrHosts hosts using fair round-robin arbitration.
- Supports pipelined, in-order transactions with up to MaxOutstanding requests in flight.
- Devices may stall with gnt and may respond with variable latency; responses are always in order.
- Sits in front of a shared memory or peripheral in demo and simulation systems, where strict-priority sharing would starve low-priority hosts.

Parameters:
- NrHosts, 2, number of requesting hosts (>=1).
- DataWidth, 32, data bus width in bits (multiple of 8).
- AddressWidth, 32, address width in bits.
- MaxOutstanding, 2, maximum accepted-but-unanswered transactions (>=1).

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_ni  input  1  reset; asynchronous, active-low.
- host_req_i  input  1 [NrHosts]  host request.
- host_gnt_o  output  1 [NrHosts]  host request accepted this cycle.
- host_addr_i  input  AddressWidth [NrHosts]  host address.
- host_we_i  input  1 [NrHosts]  write enable.
- host_be_i  input  DataWidth/8 [NrHosts]  byte enables.
- host_wdata_i  input  DataWidth [NrHosts]  write data.
- host_rvalid_o  output  1 [NrHosts]  response valid.
- host_rdata_o  output  DataWidth [NrHosts]  read data.
- host_err_o  output  1 [NrHosts]  response error.
- device_req_o  output  1  forwarded request.
- device_gnt_i  input  1  device accepts request.
- device_addr_o  output  AddressWidth  forwarded address.
- device_we_o  output  1  forwarded write enable.
- device_be_o  output  DataWidth/8  forwarded byte enables.
- device_wdata_o  output  DataWidth  forwarded write data.
- device_rvalid_i  input  1  device response valid.
- device_rdata_i  input  DataWidth  device read data.
- device_err_i  input  1  device error.
- busy_o  output  1  at least one transaction outstanding.
- orphan_rsp_o  output  1  one-cycle pulse: rvalid received with nothing outstanding.

Behaviour:
- State:
  - rr_q: priority pointer, 0..NrHosts-1.
  - cnt_q: outstanding count, 0..MaxOutstanding.
  - ID FIFO of depth MaxOutstanding holding host indices, with wrapping read and write pointers.
- Reset state: rr_q=0, cnt_q=0, FIFO empty.
  - While rst_ni is low: device_req_o=0, all host_gnt_o=0, all host_rvalid_o=0, busy_o=0, orphan_rsp_o=0.
  - Reset mid-transaction discards all outstanding IDs. Responses arriving after reset are orphans.
- Arbitration (combinational):
  - winner = first host with host_req_i set, scanning rr_q, rr_q+1, ... and wrapping modulo NrHosts.
  - fwd = any host_req_i && (cnt_q < MaxOutstanding), evaluated on the registered cnt_q only. A same-cycle pop does not free a slot.
- Device outputs:
  - When fwd: device_req_o=1 and device_addr/we/be/wdata_o are copied from the winner.
  - Otherwise: device_req_o=0 and all other device outputs are 0.
- Grant: host_gnt_o[winner] = fwd && device_gnt_i. All other host_gnt_o are 0.
- Accept event (device_req_o && device_gnt_i):
  - Push the winner index into the FIFO.
  - rr_q <= (winner+1) mod NrHosts.
- rr_q is held whenever there is no accept, including when the device stalls. The winner may change during a stall if a host with higher rotated priority raises its request. Hosts must hold their requests until granted.
- Response event (device_rvalid_i with FIFO non-empty):
  - h = FIFO head. host_rvalid_o[h]=1, host_rdata_o[h]=device_rdata_i, host_err_o[h]=device_err_i.
  - Pop the FIFO.
  - Response latency is zero cycles: combinational from the device to the host.
- Response with FIFO empty: not forwarded to any host; orphan_rsp_o=1 for that cycle.
- Non-responding hosts: rvalid, rdata and err are all 0.
- cnt_q next value = cnt_q + accept - pop. Accept and pop in the same cycle leave the count unchanged.
  - Push when full cannot occur, because fwd is gated.
- Earliest response: device_rvalid_i in the same cycle as the accept is not supported. Responses are valid one or more cycles after the accept.
- busy_o = (cnt_q != 0).
- NrHosts=1: rr_q is constant 0; the host index width is at least 1 bit.

Test Plan:
- Reset, then host0 alone issues a read at 0x100 with device_gnt_i=1 and rdata 0xDEADBEEF two cycles later → gnt0 is asserted in cycle 0; host_rvalid_o[0] is asserted with 0xDEADBEEF; busy_o is 1 then 0.
- Both hosts request continuously with device_gnt_i=1, responses after one cycle, MaxOutstanding=2 → grants alternate 0,1,0,1; each response is routed to the host recorded at accept time.
- Device holds device_gnt_i=0 for 3 cycles while both hosts request → no host_gnt; rr_q is unchanged; a grant goes to the rr_q-selected host when device_gnt_i rises.
- Issue two accepts with no responses (cnt_q=2) → device_req_o=0 despite host requests. A response in cycle N allows forwarding again in cycle N+1, not in cycle N.
- device_rvalid_i pulses with an empty FIFO → orphan_rsp_o pulses for one cycle; all host_rvalid_o stay 0.
- Assert rst_ni low with 2 outstanding transactions, then release and send one late rvalid → busy_o=0 after reset; the late response raises orphan_rsp_o; the next grant goes to host0.

Source files
------------

// File: rtl/bus_rr_arbiter.sv
// Round-robin arbiter sharing one pipelined device port between NrHosts hosts.
// Accepted transactions are tracked in an in-order host-index FIFO so responses route back.
module bus_rr_arbiter #(
   parameter int unsigned NrHosts        = 2,
   parameter int unsigned DataWidth      = 32,
   parameter int unsigned AddressWidth   = 32,
   parameter int unsigned MaxOutstanding = 2
) (
   input  logic                                   clk_i,
   input  logic                                   rst_ni,
   input  logic [NrHosts-1:0]                     host_req_i,
   output logic [NrHosts-1:0]                     host_gnt_o,
   input  logic [NrHosts-1:0][AddressWidth-1:0]   host_addr_i,
   input  logic [NrHosts-1:0]                     host_we_i,
   input  logic [NrHosts-1:0][DataWidth/8-1:0]    host_be_i,
   input  logic [NrHosts-1:0][DataWidth-1:0]      host_wdata_i,
   output logic [NrHosts-1:0]                     host_rvalid_o,
   output logic [NrHosts-1:0][DataWidth-1:0]      host_rdata_o,
   output logic [NrHosts-1:0]                     host_err_o,
   output logic                                   device_req_o,
   input  logic                                   device_gnt_i,
   output logic [AddressWidth-1:0]                device_addr_o,
   output logic                                   device_we_o,
   output logic [DataWidth/8-1:0]                 device_be_o,
   output logic [DataWidth-1:0]                   device_wdata_o,
   input  logic                                   device_rvalid_i,
   input  logic [DataWidth-1:0]                   device_rdata_i,
   input  logic                                   device_err_i,
   output logic                                   busy_o,
   output logic                                   orphan_rsp_o
);

   // Handshake: a request is transferred in the cycle where req and gnt are both
   // high; the requester must hold req and its payload stable until that cycle.
   // rvalid has no back-pressure and arrives one or more cycles after transfer.

   localparam int unsigned IdxW = (NrHosts > 1) ? $clog2(NrHosts) : 1;
   localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
   localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

   logic [IdxW-1:0] rr_q;
   logic [IdxW-1:0] winner;
   logic [IdxW-1:0] rr_next;
   logic [CntW-1:0] cnt_q;
   logic [PtrW-1:0] wr_ptr_q;
   logic [PtrW-1:0] rd_ptr_q;
   logic [IdxW-1:0] id_mem_q [MaxOutstanding];
   logic [IdxW-1:0] head;
   logic            any_req;
   logic            fwd;
   logic            accept;
   logic            fifo_empty;
   logic            pop;

   // Rotated priority scan starting at rr_q.
   always_comb begin
      logic            found;
      int unsigned     idx;
      logic [IdxW-1:0] cand;
      winner = rr_q;
      found  = 1'b0;
      for (int unsigned i = 0; i < NrHosts; i++) begin
         idx = int'(rr_q) + i;
         if (idx >= NrHosts) begin
            idx = idx - NrHosts;
         end
         cand = idx[IdxW-1:0];
         if (!found && host_req_i[cand]) begin
            winner = cand;
            found  = 1'b1;
         end
      end
   end

   assign any_req    = |host_req_i;
   assign fifo_empty = (cnt_q == '0);
   // Slot availability uses the registered count only; a pop this cycle frees nothing yet.
   assign fwd        = rst_ni && any_req && (cnt_q < CntW'(MaxOutstanding));
   assign accept     = fwd && device_gnt_i;
   assign pop        = rst_ni && device_rvalid_i && !fifo_empty;
   assign head       = id_mem_q[rd_ptr_q];
   assign rr_next    = (winner == IdxW'(NrHosts - 1)) ? '0 : winner + 1'b1;

   always_comb begin
      device_req_o   = 1'b0;
      device_addr_o  = '0;
      device_we_o    = 1'b0;
      device_be_o    = '0;
      device_wdata_o = '0;
      host_gnt_o     = '0;
      if (fwd) begin
         device_req_o   = 1'b1;
         device_addr_o  = host_addr_i[winner];
         device_we_o    = host_we_i[winner];
         device_be_o    = host_be_i[winner];
         device_wdata_o = host_wdata_i[winner];
         host_gnt_o[winner] = device_gnt_i;
      end
   end

   always_comb begin
      host_rvalid_o = '0;
      host_rdata_o  = '0;
      host_err_o    = '0;
      if (pop) begin
         host_rvalid_o[head] = 1'b1;
         host_rdata_o[head]  = device_rdata_i;
         host_err_o[head]    = device_err_i;
      end
   end

   assign busy_o       = rst_ni && !fifo_empty;
   assign orphan_rsp_o = rst_ni && device_rvalid_i && fifo_empty;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rr_q <= '0;
      end else if (accept) begin
         rr_q <= rr_next;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else if (accept && !pop) begin
         cnt_q <= cnt_q + 1'b1;
      end else if (pop && !accept) begin
         cnt_q <= cnt_q - 1'b1;
      end
   end

   // Host-index FIFO; full is impossible on push because fwd is gated by cnt_q.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         for (int unsigned i = 0; i < MaxOutstanding; i++) begin
            id_mem_q[i] <= '0;
         end
      end else begin
         if (accept) begin
            id_mem_q[wr_ptr_q] <= winner;
            wr_ptr_q <= (wr_ptr_q == PtrW'(MaxOutstanding - 1)) ? '0 : wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_q <= (rd_ptr_q == PtrW'(MaxOutstanding - 1)) ? '0 : rd_ptr_q + 1'b1;
         end
      end
   end

endmodule
